clk_freq_meter: RTL and testbench

//  Gated edge counter downstream of simple_fpga_cvs. Measures a clock under test
//  (clk_out, or any of the out[] lines) arriving as an asynchronous toggle signal.
//  The counter runs in the single measurement clock domain. It counts edges of the

---
 rtl/clk_freq_meter_pkg.sv | 21 ++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/clk_freq_meter.sv | 111 +++++++++++
 tb/tb_clk_freq_meter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_freq_meter_pkg.sv
// Shared types and helpers for the clock frequency meter.
// Holds the FSM state encoding and the gate-timer width calculation so that the
// top level and any other monitor instances size their timers consistently.
package clk_freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bits needed for a timer that counts 0..gate_cycles-1.
  function automatic int timer_width(input int gate_cycles);
    return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
  endfunction

  localparam int GATE_CYCLES_DEF = 1024;
  localparam int TIMER_W_DEF     = timer_width(GATE_CYCLES_DEF);

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser plus any-edge detector for an asynchronous level/toggle input.
// Latency: edge_pulse rises SYNC_STAGES+1 cycles after async_in changes (+/-1).
// No backpressure: one pulse per observed level change, both polarities.
// Ports: clock, reset_n (async active-low); async_in (raw input);
//        sync_out (synchronised level); edge_pulse (1-cycle pulse per level change).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_q_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], async_in};
      sync_q_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign edge_pulse = sync_q[SYNC_STAGES-1] ^ sync_q_d;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts level changes of mon_toggle over GATE_CYCLES clocks.
// Latency: result + count_valid appear the cycle after the last gate cycle.
// No backpressure: count_valid is a 1-cycle strobe; count/dead/overflow hold.
// Ports: clock, reset_n (async active-low); mon_toggle (async input under test);
//        start (arm from IDLE); continuous (re-arm from DONE); busy (ARM/MEASURE);
//        count, count_valid, dead (zero edges), overflow (count saturated).
module clk_freq_meter
  import clk_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1024,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               mon_toggle,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] count,
  output logic               count_valid,
  output logic               dead,
  output logic               overflow
);

  localparam int                 TIMER_W    = timer_width(GATE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer;
  logic [COUNT_W-1:0] acc, acc_nxt;
  logic               sat, sat_nxt;
  logic               edge_pulse;
  logic               sync_level_unused;
  logic               last_gate;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .async_in   (mon_toggle),
    .sync_out   (sync_level_unused),
    .edge_pulse (edge_pulse)
  );

  assign last_gate = (state == MEASURE) && (timer == TIMER_LAST);
  assign busy      = (state == ARM) || (state == MEASURE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = MEASURE;
      MEASURE: if (last_gate) state_nxt = DONE;
      DONE:    state_nxt = continuous ? ARM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating accumulate; sat records an edge that arrived with the count
  // already at its maximum, so reaching the maximum exactly is not overflow.
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    if (edge_pulse) begin
      if (acc == COUNT_MAX) sat_nxt = 1'b1;
      else                  acc_nxt = acc + 1'b1;
    end
  end

  // Results are loaded from acc_nxt on the last gate edge so that an edge in
  // the final gate cycle is included and the strobe lands in the DONE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer       <= '0;
      acc         <= '0;
      sat         <= 1'b0;
      count       <= '0;
      count_valid <= 1'b0;
      dead        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        ARM: begin
          timer <= '0;
          acc   <= '0;
          sat   <= 1'b0;
        end
        MEASURE: begin
          timer <= timer + 1'b1;
          acc   <= acc_nxt;
          sat   <= sat_nxt;
          if (last_gate) begin
            count       <= acc_nxt;
            dead        <= (acc_nxt == '0);
            overflow    <= sat_nxt;
            count_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Testbench for clk_freq_meter: two instances (COUNT_W=8 and COUNT_W=4, GATE=100).
module tb_clk_freq_meter;

  localparam int G = 100;

  logic       clock = 1'b0, reset_n = 1'b0, mon_toggle = 1'b0;
  logic       start = 1'b0, continuous = 1'b0, start_s = 1'b0, cont_s = 1'b0;
  logic       busy, count_valid, dead, overflow;
  logic [7:0] count;
  logic       busy_s, valid_s, dead_s, ovf_s;
  logic [3:0] count_s;

  int n_vec = 0, n_bad = 0;
  int cyc = 0;                 // number of rising edges seen so far
  bit hist[8192];              // hist[k] = mon_toggle as sampled on edge k
  int mon_mode = 0, mon_per = 1, rnd_pct = 0, ph = 0;

  clk_freq_meter #(.GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .mon_toggle(mon_toggle), .start(start),
    .continuous(continuous), .busy(busy), .count(count), .count_valid(count_valid),
    .dead(dead), .overflow(overflow));

  clk_freq_meter #(.GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(2)) dut_s (
    .clock(clock), .reset_n(reset_n), .mon_toggle(mon_toggle), .start(start_s),
    .continuous(cont_s), .busy(busy_s), .count(count_s), .count_valid(valid_s),
    .dead(dead_s), .overflow(ovf_s));

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    if (cyc < 8192) hist[cyc] = mon_toggle;
    cyc = cyc + 1;
  end

  // Stimulus on mon_toggle: 0 hold, 1 toggle every mon_per cycles, 2 random flips.
  initial forever begin
    @(posedge clock);
    #1;
    case (mon_mode)
      1: begin
        ph = ph + 1;
        if (ph >= mon_per) begin ph = 0; mon_toggle = ~mon_toggle; end
      end
      2: if ($urandom_range(0, 99) < rnd_pct) mon_toggle = ~mon_toggle;
      default: ;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int o_valid(input bit sm); return sm ? int'(valid_s) : int'(count_valid); endfunction
  function automatic int o_count(input bit sm); return sm ? int'(count_s) : int'(count);      endfunction
  function automatic int o_dead (input bit sm); return sm ? int'(dead_s)  : int'(dead);       endfunction
  function automatic int o_ovf  (input bit sm); return sm ? int'(ovf_s)   : int'(overflow);   endfunction
  function automatic int o_busy (input bit sm); return sm ? int'(busy_s)  : int'(busy);       endfunction

  // Returns 1 time unit after rising edge e.
  task automatic goto(input int e);
    while (cyc <= e) begin @(posedge clock); #1; end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic count_valids(input int n, inout int nv);
    repeat (n) begin @(posedge clock); #1; if (count_valid) nv++; end
  endtask

  // One-cycle start; s is the edge on which the DUT sampled it.
  task automatic start_meas(input bit sm, output int s);
    if (sm) start_s = 1'b1; else start = 1'b1;
    @(posedge clock); #1;
    s = cyc - 1;
    start = 1'b0; start_s = 1'b0;
  endtask

  // Reference: a level change sampled on edge i reaches the counter as a
  // pulse in cycle i+2. Gate cycles follow edges s+1..s+G, so the window
  // covers the level changes between samples s-1 .. s+G-1.
  function automatic int model(input int s, input int w);
    int n = 0;
    for (int i = s - 1; i < s + G - 1; i++)
      if (i >= 0 && i < 8191 && hist[i] != hist[i+1]) n++;
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  // Result must appear exactly after edge e (the cycle after the last gate
  // cycle; counting the start-sampling cycle as cycle 1 this is cycle G+3).
  task automatic check_window(input bit sm, input int e, input int ec, input int ed,
                              input int eo, input string tag);
    goto(e - 1);
    chk({tag, " valid_early"}, o_valid(sm), 0);
    goto(e);
    chk({tag, " valid"},    o_valid(sm), 1);
    chk({tag, " count"},    o_count(sm), ec);
    chk({tag, " dead"},     o_dead(sm),  ed);
    chk({tag, " overflow"}, o_ovf(sm),   eo);
    chk({tag, " busy_done"}, o_busy(sm), 0);
    goto(e + 1);
    chk({tag, " valid_pulse"}, o_valid(sm), 0);
  endtask

  // Continuous run of nwin windows; continuous drops mid-way through the last.
  task automatic run_cont(input int nwin, input int fixed, input string tag);
    int s, sn, e, ex, nv;
    continuous = 1'b1;
    start_meas(1'b0, s);
    for (int n = 0; n < nwin; n++) begin
      sn = s + n * (G + 2);
      e  = sn + G + 1;
      if (n == nwin - 1) begin goto(sn + 50); continuous = 1'b0; end
      goto(e - 1);
      ex = (fixed >= 0) ? fixed : model(sn, 8);
      check_window(1'b0, e, ex, (ex == 0) ? 1 : 0, 0, $sformatf("%s w%0d", tag, n));
    end
    nv = 0;
    count_valids(G + 10, nv);
    chk({tag, " no_extra_valid"}, nv, 0);
    chk({tag, " busy_after"}, busy, 0);
  endtask

  typedef struct {
    bit sm;     // 1: COUNT_W=4 instance
    int per;    // toggle period in cycles, 0 = held constant
    int cnt;
    int dd;
    int ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int s, s2, nv;

    vecs[0] = '{1'b0,  5,  20, 0, 0};
    vecs[1] = '{1'b0,  0,   0, 1, 0};
    vecs[2] = '{1'b0,  4,  25, 0, 0};
    vecs[3] = '{1'b0,  1, 100, 0, 0};
    vecs[4] = '{1'b1,  1,  15, 0, 1};
    vecs[5] = '{1'b1, 10,  10, 0, 0};
    vecs[6] = '{1'b0,  2,  50, 0, 0};
    vecs[7] = '{1'b1,  0,   0, 1, 0};
    vecs[8] = '{1'b0, 25,   4, 0, 0};

    // Reset state, before any clock edge.
    #2;
    chk("rst busy",  busy, 0);
    chk("rst count", count, 0);
    chk("rst valid", count_valid, 0);
    chk("rst dead",  dead, 0);
    chk("rst ovf",   overflow, 0);
    @(posedge clock); #1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(3);

    // Single measurements from the vector table.
    for (int i = 0; i < 9; i++) begin
      mon_mode = (vecs[i].per == 0) ? 0 : 1;
      mon_per  = (vecs[i].per == 0) ? 1 : vecs[i].per;
      ph = 0;
      wait_cyc(10);
      start_meas(vecs[i].sm, s);
      chk($sformatf("vec%0d busy_arm", i), o_busy(vecs[i].sm), 1);
      check_window(vecs[i].sm, s + G + 1, vecs[i].cnt, vecs[i].dd, vecs[i].ov,
                   $sformatf("vec%0d", i));
    end

    // start held high: one measurement per IDLE visit, period G+3.
    mon_mode = 1; mon_per = 10; ph = 0;
    wait_cyc(5);
    start = 1'b1;
    @(posedge clock); #1;
    s  = cyc - 1;
    s2 = s + G + 3;
    check_window(1'b0, s + G + 1, 10, 0, 0, "hold w0");
    goto(s2);
    chk("hold busy_rearm", busy, 1);
    check_window(1'b0, s2 + G + 1, 10, 0, 0, "hold w1");
    start = 1'b0;
    wait_cyc(3);
    chk("hold busy_end", busy, 0);

    // start pulsed during MEASURE and during DONE is ignored.
    mon_mode = 1; mon_per = 5; ph = 0;
    wait_cyc(10);
    start_meas(1'b0, s);
    nv = 0;
    count_valids(30, nv);
    start = 1'b1;
    count_valids(1, nv);
    start = 1'b0;
    count_valids(G - 30, nv);
    chk("ign count", count, 20);
    chk("ign valid", count_valid, 1);
    start = 1'b1;
    count_valids(1, nv);
    start = 1'b0;
    count_valids(150, nv);
    chk("ign n_valid", nv, 1);
    chk("ign busy", busy, 0);
    chk("ign count_held", count, 20);

    // Reset in MEASURE cycle 50 discards the window.
    start_meas(1'b0, s);
    goto(s + 51);
    reset_n = 1'b0;
    #1;
    chk("midrst busy",  busy, 0);
    chk("midrst count", count, 0);
    chk("midrst valid", count_valid, 0);
    chk("midrst dead",  dead, 0);
    chk("midrst ovf",   overflow, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    nv = 0;
    count_valids(250, nv);
    chk("midrst no_valid", nv, 0);
    chk("midrst busy_after", busy, 0);

    // Continuous mode, toggle every 4 cycles: results every G+2 cycles.
    mon_mode = 1; mon_per = 4; ph = 0;
    wait_cyc(10);
    run_cont(3, 25, "cont");

    // Random toggling in continuous mode against the reference model.
    for (int r = 0; r < 3; r++) begin
      mon_mode = 2;
      rnd_pct  = $urandom_range(5, 70);
      wait_cyc(5);
      run_cont(2 + r, -1, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
